vga_sync_gen: RTL and testbench
===============================

// Module: vga_sync_gen
// PURPOSE
//   Raster timing generator for the 640x480@60 display path. Produces the pixel
//   coordinates x/y consumed by the field/score encoder, takes its registered
//   px_data back as px_in, and drives latency-matched hsync/vsync/px_out to the
//   pins. Also gives game logic a pixel-rate enable and a once-per-frame
//   vertical-blank strobe, so ball/paddle state updates happen off-screen.
// PARAMETERS
//   CLK_DIV   4    clk cycles per pixel (1 = clk is the pixel clock; 4 = 100 MHz board clock)
//   H_ACTIVE  640  visible pixels per line
//   H_FP      16   horizontal front porch, pixels
//   H_SYNC    96   horizontal sync width, pixels
//   H_BP      48   horizontal back porch, pixels (H_TOTAL = 800)
//   V_ACTIVE  480  visible lines
//   V_FP      10   vertical front porch, lines
//   V_SYNC    2    vertical sync width, lines
//   V_BP      33   vertical back porch, lines (V_TOTAL = 525)
//   SYNC_POL  0    sync level while asserted (0 = active-low)
// PORTS
//   clk          in   1   system clock
//   rst          in   1   synchronous reset, active-high
//   px_in        in   1   pixel bit from encoder, registered 1 clk after x/y
//   x            out  11  horizontal counter h_cnt, 0..H_TOTAL-1
//   y            out  11  vertical counter v_cnt, 0..V_TOTAL-1
//   px_tick      out  1   pixel-rate enable, 1 clk wide
//   hsync        out  1   horizontal sync to pin
//   vsync        out  1   vertical sync to pin
//   video_on     out  1   visible-area flag, aligned with px_out
//   px_out       out  1   px_in gated by video_on, to pin
//   vblank_tick  out  1   1-clk strobe when v_cnt enters V_ACTIVE
// BEHAVIOUR
//   - All flops are synchronous to clk and reset by rst. There is no async path.
//   - Reset values: div_cnt=0, h_cnt=0, v_cnt=0, px_tick=0, hsync=vsync=~SYNC_POL,
//     video_on=0, px_out=0, vblank_tick=0.
//   - A mid-frame reset takes effect on the next edge. Counting restarts at
//     (0,0) on the first clk after rst falls. There is no partial-line recovery.
//   - Divider: div_cnt counts 0..CLK_DIV-1 and wraps.
//     px_tick is registered and is high for the clk after div_cnt==CLK_DIV-1,
//     so it is high every CLK_DIV clks. If CLK_DIV=1, px_tick stays high.
//   - Counters advance only on px_tick.
//     h_cnt counts 0..H_TOTAL-1 and wraps to 0.
//     On the h wrap, v_cnt increments; it wraps to 0 at V_TOTAL-1.
//     Both are 11-bit unsigned, and all comparisons are unsigned.
//   - x = h_cnt and y = v_cnt, taken directly from registers.
//     Each value is stable for CLK_DIV clks.
//   - Raw decode (combinational from counters):
//       von_r = h_cnt<H_ACTIVE && v_cnt<V_ACTIVE
//       hs_r  = H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC
//       vs_r  = V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC
//   - Latency matching (encoder = 1 clk):
//       stage 1 (every clk): von_d, hs_d, vs_d <= raw values
//       stage 2 (every clk): video_on <= von_d; px_out <= px_in & von_d;
//                            hsync <= hs_d ? SYNC_POL : ~SYNC_POL (vsync likewise)
//     Fixed 2-clk latency from a counter change to the pins, independent of CLK_DIV.
//   - px_out is never 1 while video_on=0, regardless of px_in.
//   - vblank_tick: registered, 1 clk wide. Fires on the px_tick that moves v_cnt
//     from V_ACTIVE-1 to V_ACTIVE. That is exactly one strobe per frame, and none
//     during reset.
// TESTING
//   T1 CLK_DIV=4, rst held 5 clk then released -> outputs at reset values;
//      px_tick every 4th clk; x 0->1 after the first tick.
//   T2 Line wrap -> x goes 799->0 and y increments on the same tick.
//      hsync low for 384 clk, starting 2 clk after x becomes 656.
//   T3 Frame wrap -> y goes 524->0 when x wraps.
//      vsync low for 2 lines (6400 clk), starting 2 clk after (x=0, y=490).
//      Frame period = 1,680,000 clk.
//   T4 px_in tied 1 -> px_out=1 only for x<640, y<480, shifted 2 clk.
//      px_out=0 through x=640..799 and y>=480.
//   T5 vblank_tick -> exactly one 1-clk pulse per frame, in the cycle that y
//      becomes 480. No pulse in a frame cut short by rst.
//   T6 rst pulsed at x=300, y=200 -> counters read (0,0) after release;
//      hsync/vsync=1, px_out=0. Rerun with CLK_DIV=1: px_tick constant 1 and
//      x advances every clk.

Source files
------------

// File: rtl/vga_sync_gen.sv
// Raster timing generator: pixel-rate divider, horizontal/vertical counters and
// sync/video outputs delayed to line up with a 1-clk registered pixel encoder.
module vga_sync_gen #(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter logic        SYNC_POL = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        px_in,
  output logic [10:0] x,
  output logic [10:0] y,
  output logic        px_tick,
  output logic        hsync,
  output logic        vsync,
  output logic        video_on,
  output logic        px_out,
  output logic        vblank_tick
);

  localparam int unsigned      DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
  localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] H_LAST   = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);

  localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
  localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [10:0] V_LAST   = 11'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [10:0] V_PRE    = 11'(V_ACTIVE - 1);

  logic [DIV_W-1:0] div_cnt;
  logic [10:0]      h_cnt;
  logic [10:0]      v_cnt;
  logic             von_r, hs_r, vs_r;
  logic             von_d, hs_d, vs_d;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      px_tick <= 1'b0;
    end else begin
      div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);
      px_tick <= (div_cnt == DIV_LAST);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      vblank_tick <= 1'b0;
    end else begin
      // Strobe lands in the same clk that v_cnt first shows V_ACTIVE.
      vblank_tick <= px_tick && (h_cnt == H_LAST) && (v_cnt == V_PRE);
      if (px_tick) begin
        if (h_cnt == H_LAST) begin
          h_cnt <= '0;
          v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 11'd1;
        end else begin
          h_cnt <= h_cnt + 11'd1;
        end
      end
    end
  end

  assign x = h_cnt;
  assign y = v_cnt;

  // NOTE: defaults come first so no path through a combinational block can infer a latch.
  always_comb begin
    von_r = 1'b0;
    hs_r  = 1'b0;
    vs_r  = 1'b0;
    if (h_cnt < H_ACT && v_cnt < V_ACT)         von_r = 1'b1;
    if (h_cnt >= HS_START && h_cnt < HS_END)    hs_r  = 1'b1;
    if (v_cnt >= VS_START && v_cnt < VS_END)    vs_r  = 1'b1;
  end

  // Two stages: one to match the encoder register, one to drive the pins.
  always_ff @(posedge clk) begin
    if (rst) begin
      von_d    <= 1'b0;
      hs_d     <= 1'b0;
      vs_d     <= 1'b0;
      video_on <= 1'b0;
      px_out   <= 1'b0;
      hsync    <= ~SYNC_POL;
      vsync    <= ~SYNC_POL;
    end else begin
      von_d    <= von_r;
      hs_d     <= hs_r;
      vs_d     <= vs_r;
      video_on <= von_d;
      px_out   <= px_in & von_d;
      hsync    <= hs_d ? SYNC_POL : ~SYNC_POL;
      vsync    <= vs_d ? SYNC_POL : ~SYNC_POL;
    end
  end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen on a shrunken raster (25x15) at CLK_DIV=4 and CLK_DIV=1,
// compared against a closed-form model indexed by clocks since reset release.
module tb_vga_sync_gen;

  localparam int HA = 16, HFP = 2, HSW = 4, HBP = 3, HT = HA + HFP + HSW + HBP;
  localparam int VA = 8,  VFP = 2, VSW = 2, VBP = 3, VT = VA + VFP + VSW + VBP;
  localparam int D0 = 4, D1 = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        px_in = 1'b0;
  logic [10:0] x0, y0, x1, y1;
  logic        tick0, hs0, vs0, von0, pxo0, vb0;
  logic        tick1, hs1, vs1, von1, pxo1, vb1;
  logic [27:0] act0, act1;

  int checks = 0;
  int errors = 0;
  int n = 0;            // posedges since rst was last seen high
  logic pxin_edge = 1'b0;

  always #5 clk = ~clk;

  vga_sync_gen #(.CLK_DIV(D0), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
                 .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP), .SYNC_POL(1'b0)) dut0 (
    .clk(clk), .rst(rst), .px_in(px_in), .x(x0), .y(y0), .px_tick(tick0), .hsync(hs0),
    .vsync(vs0), .video_on(von0), .px_out(pxo0), .vblank_tick(vb0));

  vga_sync_gen #(.CLK_DIV(D1), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
                 .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP), .SYNC_POL(1'b0)) dut1 (
    .clk(clk), .rst(rst), .px_in(px_in), .x(x1), .y(y1), .px_tick(tick1), .hsync(hs1),
    .vsync(vs1), .video_on(von1), .px_out(pxo1), .vblank_tick(vb1));

  assign act0 = {x0, y0, tick0, hs0, vs0, von0, pxo0, vb0};
  assign act1 = {x1, y1, tick1, hs1, vs1, von1, pxo1, vb1};

  always @(posedge clk) begin
    n         <= rst ? 0 : n + 1;
    pxin_edge <= px_in;
  end

  // ---------------- reference model ----------------
  function automatic int pix(int k, int d);
    return (k <= 0) ? 0 : ((k - 1) / d) % (HT * VT);
  endfunction
  function automatic logic [10:0] exp_x(int k, int d);
    return 11'(pix(k, d) % HT);
  endfunction
  function automatic logic [10:0] exp_y(int k, int d);
    return 11'(pix(k, d) / HT);
  endfunction
  function automatic logic exp_tick(int k, int d);
    return (k >= d) && (k % d == 0);
  endfunction
  function automatic logic exp_von(int k, int d);
    if (k < 2) return 1'b0;
    return (int'(exp_x(k - 2, d)) < HA) && (int'(exp_y(k - 2, d)) < VA);
  endfunction
  function automatic logic exp_hs(int k, int d);
    int h;
    if (k < 2) return 1'b1;
    h = int'(exp_x(k - 2, d));
    return !(h >= HA + HFP && h < HA + HFP + HSW);
  endfunction
  function automatic logic exp_vs(int k, int d);
    int v;
    if (k < 2) return 1'b1;
    v = int'(exp_y(k - 2, d));
    return !(v >= VA + VFP && v < VA + VFP + VSW);
  endfunction
  function automatic logic exp_vb(int k, int d);
    if (k < 1) return 1'b0;
    return (int'(exp_y(k, d)) == VA) && (int'(exp_y(k - 1, d)) == VA - 1);
  endfunction
  function automatic logic [27:0] exp_vec(int k, int d, logic pin);
    logic von;
    von = exp_von(k, d);
    return {exp_x(k, d), exp_y(k, d), exp_tick(k, d), exp_hs(k, d), exp_vs(k, d),
            von, pin & von, exp_vb(k, d)};
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (act0 !== {22'd0, 6'b011000}) begin
        errors++;
        $display("FAIL reset_dut0: got %h expected %h", act0, {22'd0, 6'b011000});
      end
      checks++;
      if (act1 !== {22'd0, 6'b011000}) begin
        errors++;
        $display("FAIL reset_dut1: got %h expected %h", act1, {22'd0, 6'b011000});
      end
    end
  endtask

  task automatic test_divider();
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      checks++;
      if (act0 !== exp_vec(n, D0, pxin_edge)) begin
        errors++;
        $display("FAIL divider_vec n=%0d: got %h expected %h", n, act0, exp_vec(n, D0, pxin_edge));
      end
      if (n <= 4) begin
        checks++;
        if (tick0 !== (n == 4) || x0 !== 11'd0) begin
          errors++;
          $display("FAIL divider_start n=%0d: tick=%b x=%0d expected tick=%b x=0", n, tick0, x0, n == 4);
        end
      end else if (n == 5) begin
        checks++;
        if (x0 !== 11'd1 || tick0 !== 1'b0) begin
          errors++;
          $display("FAIL first_advance: x=%0d tick=%b expected x=1 tick=0", x0, tick0);
        end
      end
    end
  endtask

  task automatic test_random_run(input string name, input int cycles);
    int shown = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      checks++;
      if (act0 !== exp_vec(n, D0, pxin_edge)) begin
        errors++;
        if (shown++ < 10)
          $display("FAIL %s_dut0 n=%0d: got %h expected %h", name, n, act0, exp_vec(n, D0, pxin_edge));
      end
      checks++;
      if (act1 !== exp_vec(n, D1, pxin_edge)) begin
        errors++;
        if (shown++ < 10)
          $display("FAIL %s_dut1 n=%0d: got %h expected %h", name, n, act1, exp_vec(n, D1, pxin_edge));
      end
      px_in = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic test_sync_widths();
    int hlen = 0, vlen = 0, hruns = 0, vruns = 0, pulses = 0, last_vb = -1;
    logic hs_prev = 1'b0, vs_prev = 1'b0, vb_prev = 1'b0;
    for (int i = 0; i < 3300; i++) begin
      @(negedge clk);
      if (hs0 === 1'b0) hlen++;
      if (hs0 === 1'b1 && hs_prev === 1'b0 && hlen > 0) begin
        hruns++;
        checks++;
        if (hlen != HSW * D0) begin
          errors++;
          $display("FAIL hsync_width: got %0d clk expected %0d clk", hlen, HSW * D0);
        end
      end
      if (hs0 === 1'b1) hlen = 0;
      if (vs0 === 1'b0) vlen++;
      if (vs0 === 1'b1 && vs_prev === 1'b0 && vlen > 0 && vruns++ > 0) begin
        checks++;
        if (vlen != VSW * HT * D0) begin
          errors++;
          $display("FAIL vsync_width: got %0d clk expected %0d clk", vlen, VSW * HT * D0);
        end
      end
      if (vs0 === 1'b1) vlen = 0;
      if (vb0 === 1'b1) begin
        checks++;
        if (vb_prev === 1'b1 || y0 !== 11'(VA)) begin
          errors++;
          $display("FAIL vblank_shape: y=%0d prev=%b expected y=%0d prev=0", y0, vb_prev, VA);
        end
        if (last_vb >= 0) begin
          checks++;
          if (n - last_vb != HT * VT * D0) begin
            errors++;
            $display("FAIL frame_period: got %0d clk expected %0d clk", n - last_vb, HT * VT * D0);
          end
        end
        last_vb = n;
        pulses++;
      end
      hs_prev = hs0; vs_prev = vs0; vb_prev = vb0;
    end
    checks++;
    if (hruns < 10 || pulses != 2) begin
      errors++;
      $display("FAIL sync_activity: hruns=%0d vblank_pulses=%0d expected >=10 and 2", hruns, pulses);
    end
  endtask

  task automatic test_px_gate();
    px_in = 1'b1;
    for (int i = 0; i < 1600; i++) begin
      @(negedge clk);
      checks++;
      if (pxo0 !== exp_von(n, D0) || pxo1 !== exp_von(n, D1)) begin
        errors++;
        $display("FAIL px_gate n=%0d: got %b/%b expected %b/%b", n, pxo0, pxo1, exp_von(n, D0), exp_von(n, D1));
      end
      checks++;
      if ((pxo0 & ~von0) !== 1'b0 || (pxo1 & ~von1) !== 1'b0) begin
        errors++;
        $display("FAIL px_outside_video n=%0d: px_out=%b/%b video_on=%b/%b expected no px_out", n, pxo0, pxo1, von0, von1);
      end
    end
  endtask

  task automatic test_mid_reset();
    int budget = 3000;
    while (!(exp_x(n, D0) == 11'd12 && exp_y(n, D0) == 11'd5) && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    checks++;
    if (budget == 0) begin
      errors++;
      $display("FAIL mid_reset_seek: position x=12 y=5 not reached, got x=%0d y=%0d", x0, y0);
    end
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (act0 !== {22'd0, 6'b011000} || act1 !== {22'd0, 6'b011000}) begin
        errors++;
        $display("FAIL mid_reset_hold: got %h/%h expected %h", act0, act1, {22'd0, 6'b011000});
      end
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (x0 !== 11'd0 || y0 !== 11'd0 || hs0 !== 1'b1 || vs0 !== 1'b1 || pxo0 !== 1'b0 || vb0 !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_release: x=%0d y=%0d hs=%b vs=%b px=%b vb=%b expected 0 0 1 1 0 0",
               x0, y0, hs0, vs0, pxo0, vb0);
    end
  endtask

  task automatic test_clkdiv1();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (tick1 !== 1'b1 || x1 !== exp_x(n, D1)) begin
        errors++;
        $display("FAIL clkdiv1 n=%0d: tick=%b x=%0d expected tick=1 x=%0d", n, tick1, x1, exp_x(n, D1));
      end
    end
  endtask

  initial begin
    test_reset();
    test_divider();
    test_random_run("random_run", 3100);
    test_sync_widths();
    test_px_gate();
    test_mid_reset();
    test_clkdiv1();
    test_random_run("after_reset", 900);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
